// File: rtl/mvau_inp_dbuf_if.sv
// rtl/mvau_inp_dbuf_if.sv - stream ports of the MVAU ping-pong input activation buffer
//   in/in_v/in_rdy          : activation word stream into the buffer
//   out/out_v/out_rdy       : replayed activation words towards the MAC array
//   sf_last/nf_last         : qualify out (last word of a replay / word of final replay)
//   slave modport = buffer side, master modport = producer/consumer side
interface mvau_inp_dbuf_if #(
    parameter int TI = 8
);
    logic [TI-1:0] in;
    logic          in_v;
    logic          in_rdy;
    logic [TI-1:0] out;
    logic          out_v;
    logic          out_rdy;
    logic          sf_last;
    logic          nf_last;

    modport slave (
        input  in, in_v, out_rdy,
        output in_rdy, out, out_v, sf_last, nf_last
    );

    modport master (
        output in, in_v, out_rdy,
        input  in_rdy, out, out_v, sf_last, nf_last
    );
endinterface

// File: rtl/mvau_inp_dbuf.sv
// rtl/mvau_inp_dbuf.sv - ping-pong input activation buffer replaying each vector NF times
//   aclk   : clock, all state on the rising edge
//   areset : asynchronous active-high reset
//   s      : stream bundle (slave side), see mvau_inp_dbuf_if
module mvau_inp_dbuf #(
    parameter int SIMD     = 2,
    parameter int TSrcI    = 4,
    parameter int TI       = SIMD * TSrcI,
    parameter int SF       = 8,
    parameter int NF       = 4,
    parameter int BUF_ADDR = (SF > 1) ? $clog2(SF) : 1
) (
    input  logic           aclk,
    input  logic           areset,
    mvau_inp_dbuf_if.slave s
);

    localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
    localparam int EW   = TI + 2;  // skid entry: {nf_last, sf_last, word}
    localparam logic [BUF_ADDR-1:0] RA_LAST = BUF_ADDR'(SF - 1);
    localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

    typedef enum logic {IDLE, RUN} state_e;

    logic [TI-1:0]       bank_mem [2][SF];
    logic [1:0]          full_q, full_d;
    logic                wb_q, wb_d, rb_q, rb_d;
    logic [BUF_ADDR-1:0] wa_q, wa_d, ra_q, ra_d;
    logic [NF_W-1:0]     nf_q, nf_d;
    state_e              state_q, state_d;
    logic [EW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [1:0]          cnt_q, cnt_d;

    logic          in_rdy_int, wr_acc, rd_issue, pop, skid_ok;
    logic [EW-1:0] rd_entry;

    // in_rdy only looks at registered flags, so a freed bank is writable one cycle later
    assign in_rdy_int = !areset && !full_q[wb_q];
    assign wr_acc     = s.in_v && in_rdy_int;
    assign pop        = (cnt_q != 2'd0) && s.out_rdy;
    // Issue only when the skid has a free slot regardless of this cycle's pop,
    // which keeps out_rdy out of the read-issue path and still sustains 1 word/cycle.
    assign skid_ok    = (cnt_q != 2'd2);
    // The skid head register doubles as the synchronous RAM read register.
    assign rd_entry   = {nf_q == NF_LAST, ra_q == RA_LAST, bank_mem[rb_q][ra_q]};

    assign s.in_rdy  = in_rdy_int;
    assign s.out_v   = (cnt_q != 2'd0);
    assign s.out     = head_q[TI-1:0];
    assign s.sf_last = head_q[TI];
    assign s.nf_last = head_q[TI+1];

    always_comb begin
        full_d   = full_q;
        wb_d     = wb_q;
        wa_d     = wa_q;
        rb_d     = rb_q;
        ra_d     = ra_q;
        nf_d     = nf_q;
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        rd_issue = 1'b0;

        if (wr_acc) begin
            if (wa_q == RA_LAST) begin
                wa_d         = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                wa_d = wa_q + BUF_ADDR'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (full_q[rb_q]) begin
                    state_d  = RUN;
                    rd_issue = skid_ok;
                end
            end
            RUN: rd_issue = skid_ok;
            default: state_d = IDLE;
        endcase

        // The write side only ever completes an empty bank and the read side only
        // frees a full one, so the two full_d updates never target the same bank.
        if (rd_issue) begin
            if (ra_q == RA_LAST) begin
                ra_d = '0;
                if (nf_q == NF_LAST) begin
                    nf_d         = '0;
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                    state_d      = full_q[~rb_q] ? RUN : IDLE;
                end else begin
                    nf_d = nf_q + NF_W'(1);
                end
            end else begin
                ra_d = ra_q + BUF_ADDR'(1);
            end
        end

        unique case (cnt_q)
            2'd0: begin
                if (rd_issue) begin
                    head_d = rd_entry;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (rd_issue && pop) begin
                    head_d = rd_entry;
                end else if (rd_issue) begin
                    tail_d = rd_entry;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            full_q  <= '0;
            wb_q    <= 1'b0;
            rb_q    <= 1'b0;
            wa_q    <= '0;
            ra_q    <= '0;
            nf_q    <= '0;
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            full_q  <= full_d;
            wb_q    <= wb_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
            ra_q    <= ra_d;
            nf_q    <= nf_d;
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bank storage carries no reset; validity is tracked solely by full_q.
    always_ff @(posedge aclk) begin
        if (wr_acc) begin
            bank_mem[wb_q][wa_q] <= s.in;
        end
    end

endmodule
